// File: rtl/lpddr3_lane_read_train_fsm.sv
// rtl/lpddr3_lane_read_train_fsm.sv - per-lane LPDDR3 read-training sequencer
// Sweeps each DQ bit's RX delay, finds the first passing eye window and parks at its centre.
module lpddr3_lane_read_train_fsm #(
  parameter int NUM_BITS      = 8,
  parameter int TAP_W         = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_CYCLES = 32
) (
  input  logic                      FAB_CLK,
  input  logic                      RX_SYNC_RST,
  input  logic                      START,
  output logic                      BUSY,
  output logic                      DONE,
  input  logic [NUM_BITS-1:0]       EYE_MONITOR_EARLY,
  input  logic [NUM_BITS-1:0]       EYE_MONITOR_LATE,
  input  logic [NUM_BITS-1:0]       DELAY_LINE_OUT_OF_RANGE,
  output logic [NUM_BITS-1:0]       DELAY_LINE_LOAD,
  output logic [NUM_BITS-1:0]       DELAY_LINE_MOVE,
  output logic [NUM_BITS-1:0]       DELAY_LINE_DIRECTION,
  output logic [NUM_BITS-1:0]       EYE_MONITOR_CLEAR_FLAGS,
  output logic [NUM_BITS*TAP_W-1:0] TAP_CENTER,
  output logic [NUM_BITS-1:0]       FAIL
);

  localparam int BIT_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [TAP_W-1:0] MAX_TAP  = '1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NUM_BITS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CLEAR, S_SAMPLE, S_EVAL, S_STEP,
    S_CENTER, S_DEC_HI, S_DEC_LO, S_RELOAD, S_NEXT, S_FIN
  } state_t;

  state_t                    state, next_state;
  logic [BIT_W-1:0]          bit_idx;
  logic [TAP_W-1:0]          cur, first, last, ctr;
  logic                      found, bad;
  logic [CNT_W-1:0]          cnt;
  logic [NUM_BITS*TAP_W-1:0] tap_center_q;
  logic [NUM_BITS-1:0]       fail_q;

  logic [NUM_BITS-1:0]       sel;
  logic                      oor_b, pass;
  logic [TAP_W:0]            sum;
  logic [TAP_W-1:0]          ctr_c;

  assign sel        = NUM_BITS'(1) << bit_idx;
  assign oor_b      = DELAY_LINE_OUT_OF_RANGE[bit_idx];
  assign pass       = !bad && !oor_b;
  assign sum        = {1'b0, first} + {1'b0, last};
  assign ctr_c      = sum[TAP_W:1];
  assign TAP_CENTER = tap_center_q;
  assign FAIL       = fail_q;

  always_comb begin
    next_state              = state;
    BUSY                    = (state != S_IDLE) && (state != S_FIN);
    DONE                    = 1'b0;
    DELAY_LINE_LOAD         = '0;
    DELAY_LINE_MOVE         = '0;
    DELAY_LINE_DIRECTION    = '0;
    EYE_MONITOR_CLEAR_FLAGS = '0;
    case (state)
      S_IDLE:   if (START) next_state = S_LOAD;
      S_LOAD: begin
        DELAY_LINE_LOAD = sel;
        next_state      = S_SETTLE;
      end
      S_SETTLE: if (cnt == CNT_W'(SETTLE_CYCLES - 1)) next_state = S_CLEAR;
      S_CLEAR: begin
        EYE_MONITOR_CLEAR_FLAGS = sel;
        next_state              = S_SAMPLE;
      end
      S_SAMPLE: if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) next_state = S_EVAL;
      S_EVAL: begin
        // A failing tap after a pass closes the first window; later windows are never seen.
        if (!pass && found)                 next_state = S_CENTER;
        else if (cur == MAX_TAP || oor_b)   next_state = S_CENTER;
        else                                next_state = S_STEP;
      end
      S_STEP: begin
        DELAY_LINE_MOVE      = sel;
        DELAY_LINE_DIRECTION = sel;
        next_state           = S_SETTLE;
      end
      S_CENTER: begin
        if (!found)             next_state = S_RELOAD;
        else if (cur == ctr_c)  next_state = S_NEXT;
        else                    next_state = S_DEC_HI;
      end
      S_DEC_HI: begin
        DELAY_LINE_MOVE = sel;
        next_state      = S_DEC_LO;
      end
      S_DEC_LO: next_state = (cur == ctr) ? S_NEXT : S_DEC_HI;
      S_RELOAD: begin
        DELAY_LINE_LOAD = sel;
        next_state      = S_NEXT;
      end
      S_NEXT:   next_state = (bit_idx == LAST_BIT) ? S_FIN : S_LOAD;
      S_FIN: begin
        DONE       = 1'b1;
        next_state = S_IDLE;
      end
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      state        <= S_IDLE;
      bit_idx      <= '0;
      cur          <= '0;
      first        <= '0;
      last         <= '0;
      ctr          <= '0;
      found        <= 1'b0;
      bad          <= 1'b0;
      cnt          <= '0;
      tap_center_q <= '0;
      fail_q       <= '0;
    end else begin
      state <= next_state;
      case (state)
        S_IDLE: if (START) begin
          bit_idx      <= '0;
          fail_q       <= '0;
          tap_center_q <= '0;
        end
        S_LOAD: begin
          cur   <= '0;
          found <= 1'b0;
          cnt   <= '0;
        end
        S_SETTLE: cnt <= (next_state == S_SETTLE) ? cnt + 1'b1 : '0;
        S_CLEAR: begin
          bad <= 1'b0;
          cnt <= '0;
        end
        S_SAMPLE: begin
          bad <= bad | EYE_MONITOR_EARLY[bit_idx] | EYE_MONITOR_LATE[bit_idx];
          cnt <= (next_state == S_SAMPLE) ? cnt + 1'b1 : '0;
        end
        S_EVAL: if (pass) begin
          if (!found) begin
            first <= cur;
            found <= 1'b1;
          end
          last <= cur;
        end
        S_STEP:   cur <= cur + 1'b1;
        S_CENTER: begin
          ctr <= ctr_c;
          if (!found) begin
            fail_q[bit_idx]                       <= 1'b1;
            tap_center_q[bit_idx*TAP_W +: TAP_W]  <= '0;
          end else if (cur == ctr_c) begin
            tap_center_q[bit_idx*TAP_W +: TAP_W]  <= ctr_c;
          end
        end
        S_DEC_HI: cur <= cur - 1'b1;
        S_DEC_LO: if (cur == ctr) tap_center_q[bit_idx*TAP_W +: TAP_W] <= ctr;
        S_NEXT:   if (bit_idx != LAST_BIT) bit_idx <= bit_idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lpddr3_lane_read_train_fsm.sv
// tb/tb_lpddr3_lane_read_train_fsm.sv - directed bench for lpddr3_lane_read_train_fsm
// Models two IODs (tap counter, sticky eye flags, out-of-range) around the sequencer.
module tb_lpddr3_lane_read_train_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done;
  logic [1:0] early, late, oor;
  logic [1:0] dl_load, dl_move, dl_dir, clr_flags;
  logic [7:0] tap_center;
  logic [1:0] fail;

  always #5 clk = ~clk;

  lpddr3_lane_read_train_fsm #(
    .NUM_BITS(2), .TAP_W(4), .SETTLE_CYCLES(2), .SAMPLE_CYCLES(4)
  ) dut (
    .FAB_CLK(clk), .RX_SYNC_RST(rst), .START(start), .BUSY(busy), .DONE(done),
    .EYE_MONITOR_EARLY(early), .EYE_MONITOR_LATE(late),
    .DELAY_LINE_OUT_OF_RANGE(oor), .DELAY_LINE_LOAD(dl_load),
    .DELAY_LINE_MOVE(dl_move), .DELAY_LINE_DIRECTION(dl_dir),
    .EYE_MONITOR_CLEAR_FLAGS(clr_flags), .TAP_CENTER(tap_center), .FAIL(fail)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int tap[2]    = '{0, 0};
  int lo[2]     = '{0, 0};
  int hi[2]     = '{15, 15};
  int oor_at[2] = '{99, 99};
  logic [1:0] inject = 2'b00;
  logic [1:0] sticky_e = 2'b00, sticky_l = 2'b00;
  logic [1:0] raw_e, raw_l;

  int inc_cnt[2] = '{0, 0}, dec_cnt[2] = '{0, 0}, load_cnt[2] = '{0, 0};
  int done_cnt = 0, done_busy_err = 0, slice_err = 0;
  int b_inc[2], b_dec[2], b_load[2], b_done;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      raw_e[i] = (tap[i] < lo[i]) || inject[i];
      raw_l[i] = tap[i] > hi[i];
      oor[i]   = tap[i] >= oor_at[i];
      early[i] = sticky_e[i] | raw_e[i];
      late[i]  = sticky_l[i] | raw_l[i];
    end
  end

  always @(negedge clk) begin
    if ($countones(dl_load | dl_move | clr_flags) > 1) slice_err++;
    if (done) begin
      done_cnt++;
      if (busy) done_busy_err++;
    end
    for (int i = 0; i < 2; i++) begin
      if (clr_flags[i]) begin
        sticky_e[i] = 1'b0;
        sticky_l[i] = 1'b0;
      end else begin
        sticky_e[i] = sticky_e[i] | raw_e[i];
        sticky_l[i] = sticky_l[i] | raw_l[i];
      end
      if (dl_load[i]) begin
        tap[i] = 0;
        load_cnt[i]++;
      end else if (dl_move[i]) begin
        if (dl_dir[i]) begin
          tap[i] = tap[i] + 1;
          inc_cnt[i]++;
        end else begin
          tap[i] = tap[i] - 1;
          dec_cnt[i]++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      b_inc[i]  = inc_cnt[i];
      b_dec[i]  = dec_cnt[i];
      b_load[i] = load_cnt[i];
    end
    b_done = done_cnt;
  endtask

  task automatic cfg(input int lo0, input int hi0, input int oor0,
                     input int lo1, input int hi1, input int oor1);
    lo[0] = lo0; hi[0] = hi0; oor_at[0] = oor0;
    lo[1] = lo1; hi[1] = hi1; oor_at[1] = oor1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (done_cnt == b_done && k < 3000) begin
      tick(1);
      k++;
    end
    tick(2);
    n_checks++;
    if (done_cnt - b_done !== 1) begin
      n_fail++;
      $display("FAIL done_count: got %0d want 1 (waited %0d cycles)", done_cnt - b_done, k);
    end
    n_checks++;
    if (done_busy_err !== 0) begin
      n_fail++;
      $display("FAIL done_with_busy: got %0d want 0", done_busy_err);
    end
  endtask

  task automatic test_reset();
    tick(3);
    rst = 1'b0;
    tick(1);
    n_checks++;
    if ({busy, done, dl_load, dl_move, dl_dir, clr_flags, tap_center, fail} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0",
               {busy, done, dl_load, dl_move, dl_dir, clr_flags, tap_center, fail});
    end
  endtask

  task automatic test_basic_windows();
    cfg(5, 9, 99, 3, 3, 99);
    snap();
    pulse_start();
    wait_done();
    n_checks++;
    if (inc_cnt[0] - b_inc[0] !== 10 || dec_cnt[0] - b_dec[0] !== 3) begin
      n_fail++;
      $display("FAIL basic_bit0_moves: got inc %0d dec %0d want 10 3",
               inc_cnt[0] - b_inc[0], dec_cnt[0] - b_dec[0]);
    end
    n_checks++;
    if (inc_cnt[1] - b_inc[1] !== 4 || dec_cnt[1] - b_dec[1] !== 1) begin
      n_fail++;
      $display("FAIL basic_bit1_moves: got inc %0d dec %0d want 4 1",
               inc_cnt[1] - b_inc[1], dec_cnt[1] - b_dec[1]);
    end
    n_checks++;
    if (tap_center !== 8'h37 || fail !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_result: got center %h fail %b want 37 00", tap_center, fail);
    end
    n_checks++;
    if (tap[0] !== 7 || tap[1] !== 3) begin
      n_fail++;
      $display("FAIL basic_parked_taps: got %0d %0d want 7 3", tap[0], tap[1]);
    end
  endtask

  task automatic test_no_window();
    cfg(99, 99, 99, 2, 6, 99);
    snap();
    pulse_start();
    wait_done();
    n_checks++;
    if (inc_cnt[0] - b_inc[0] !== 15 || load_cnt[0] - b_load[0] !== 2) begin
      n_fail++;
      $display("FAIL nowin_bit0: got inc %0d loads %0d want 15 2",
               inc_cnt[0] - b_inc[0], load_cnt[0] - b_load[0]);
    end
    n_checks++;
    if (fail !== 2'b01 || tap_center !== 8'h40) begin
      n_fail++;
      $display("FAIL nowin_result: got fail %b center %h want 01 40", fail, tap_center);
    end
    n_checks++;
    if (tap[0] !== 0 || dec_cnt[1] - b_dec[1] !== 3) begin
      n_fail++;
      $display("FAIL nowin_taps: got tap0 %0d dec1 %0d want 0 3", tap[0], dec_cnt[1] - b_dec[1]);
    end
  endtask

  task automatic test_out_of_range();
    cfg(8, 15, 12, 0, 0, 99);
    snap();
    pulse_start();
    wait_done();
    n_checks++;
    if (inc_cnt[0] - b_inc[0] !== 12 || dec_cnt[0] - b_dec[0] !== 3) begin
      n_fail++;
      $display("FAIL oor_bit0_moves: got inc %0d dec %0d want 12 3",
               inc_cnt[0] - b_inc[0], dec_cnt[0] - b_dec[0]);
    end
    n_checks++;
    if (tap_center !== 8'h09 || fail !== 2'b00) begin
      n_fail++;
      $display("FAIL oor_result: got center %h fail %b want 09 00", tap_center, fail);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int k = 0;
    cfg(99, 99, 99, 3, 3, 99);
    snap();
    pulse_start();
    while (clr_flags[1] !== 1'b1 && k < 3000) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (clr_flags[1] !== 1'b1 || fail !== 2'b01) begin
      n_fail++;
      $display("FAIL midreset_reach_bit1: got clr %b fail %b want 1 01", clr_flags[1], fail);
    end
    tick(1);
    rst = 1'b1;
    tick(1);
    n_checks++;
    if ({busy, done, dl_load, dl_move, dl_dir, clr_flags, tap_center, fail} !== 20'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h want 0",
               {busy, done, dl_load, dl_move, dl_dir, clr_flags, tap_center, fail});
    end
    rst = 1'b0;
    tick(40);
    n_checks++;
    if (done_cnt !== b_done || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_done: got dones %0d busy %b want 0 0", done_cnt - b_done, busy);
    end
    cfg(5, 9, 99, 3, 3, 99);
    snap();
    pulse_start();
    wait_done();
    n_checks++;
    if (tap_center !== 8'h37 || fail !== 2'b00 || load_cnt[0] - b_load[0] !== 1) begin
      n_fail++;
      $display("FAIL midreset_restart: got center %h fail %b loads0 %0d want 37 00 1",
               tap_center, fail, load_cnt[0] - b_load[0]);
    end
  endtask

  task automatic test_start_while_busy();
    int k = 0;
    cfg(0, 2, 99, 5, 9, 99);
    snap();
    start = 1'b1;
    while (dl_load[0] !== 1'b1 && k < 10) begin
      tick(1);
      k++;
    end
    start = 1'b0;
    inject[0] = 1'b1;
    tick(1);
    inject[0] = 1'b0;
    tick(3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done();
    n_checks++;
    if (load_cnt[0] - b_load[0] !== 1 || inc_cnt[0] - b_inc[0] !== 3 || dec_cnt[0] - b_dec[0] !== 2) begin
      n_fail++;
      $display("FAIL busy_start_bit0: got loads %0d inc %0d dec %0d want 1 3 2",
               load_cnt[0] - b_load[0], inc_cnt[0] - b_inc[0], dec_cnt[0] - b_dec[0]);
    end
    n_checks++;
    if (tap_center !== 8'h71 || fail !== 2'b00) begin
      n_fail++;
      $display("FAIL busy_start_result: got center %h fail %b want 71 00", tap_center, fail);
    end
    tick(20);
    n_checks++;
    if (busy !== 1'b0 || done_cnt - b_done !== 1) begin
      n_fail++;
      $display("FAIL busy_start_no_restart: got busy %b dones %0d want 0 1", busy, done_cnt - b_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic_windows();
    test_no_window();
    test_out_of_range();
    test_reset_mid_sweep();
    test_start_while_busy();
    n_checks++;
    if (slice_err !== 0) begin
      n_fail++;
      $display("FAIL slice_isolation: got %0d multi-bit pulses want 0", slice_err);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
